// File: rtl/mux_nto1_buf.sv
// ============================================================================
// Module   : mux_nto1_buf
// Purpose  : N-channel valid/ready mux, fixed-select or round-robin grant,
//            feeding a 2-entry output FIFO. Optional macro MUX_HIGHZ_EN
//            tristates out_data/out_ch while the buffer is empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_nto1_buf #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int              C_DEPTH   = 2;
  localparam logic [SELW-1:0] C_LAST_CH = SELW'(NCH - 1);

  logic [1:0]       r_count;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [WIDTH-1:0] r_buf_data [C_DEPTH];
  logic [SELW-1:0]  r_buf_ch   [C_DEPTH];
  logic [SELW-1:0]  r_last_grant;

  logic             w_gnt_valid;
  logic [SELW-1:0]  w_gnt;
  logic [WIDTH-1:0] w_gnt_data;
  logic             w_space;
  logic             w_push;
  logic             w_pop;
  int               w_off;
  int               w_best_off;

  // Round-robin priority is the distance from last_grant+1, so the smallest
  // offset among requesting channels wins.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt       = '0;
    w_off       = 0;
    w_best_off  = NCH;
    if (!mode) begin
      for (int k = 0; k < NCH; k++) begin
        if (sel == SELW'(k) && in_valid[k]) begin
          w_gnt_valid = 1'b1;
          w_gnt       = SELW'(k);
        end
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        w_off = k - int'(r_last_grant) - 1;
        if (w_off < 0) begin
          w_off = w_off + NCH;
        end
        if (in_valid[k] && (w_off < w_best_off)) begin
          w_best_off  = w_off;
          w_gnt_valid = 1'b1;
          w_gnt       = SELW'(k);
        end
      end
    end
  end

  always_comb begin
    w_gnt_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (w_gnt == SELW'(k)) begin
        w_gnt_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Ready looks only at the registered fill level, never at out_ready.
  assign w_space = (r_count < 2'd2) && rst_n;

  always_comb begin
    in_ready = '0;
    for (int k = 0; k < NCH; k++) begin
      in_ready[k] = w_gnt_valid && w_space && (w_gnt == SELW'(k));
    end
  end

  assign w_push    = w_gnt_valid && w_space;
  assign out_valid = (r_count != 2'd0);
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count      <= 2'd0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_last_grant <= C_LAST_CH;
      for (int e = 0; e < C_DEPTH; e++) begin
        r_buf_data[e] <= '0;
        r_buf_ch[e]   <= '0;
      end
    end else begin
      if (w_push) begin
        r_buf_data[r_wr_ptr] <= w_gnt_data;
        r_buf_ch[r_wr_ptr]   <= w_gnt;
        r_wr_ptr             <= ~r_wr_ptr;
        r_last_grant         <= w_gnt;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef MUX_HIGHZ_EN
  assign out_data = out_valid ? r_buf_data[r_rd_ptr] : {WIDTH{1'bz}};
  assign out_ch   = out_valid ? r_buf_ch[r_rd_ptr]   : {SELW{1'bz}};
`else
  assign out_data = out_valid ? r_buf_data[r_rd_ptr] : '0;
  assign out_ch   = out_valid ? r_buf_ch[r_rd_ptr]   : '0;
`endif

endmodule

`default_nettype wire
